// File: rtl/instruction_memory.sv
// instruction_memory: word-organised instruction store for the single-cycle core.
// Byte PC addresses from BASE_ADDR map to 32-bit words; reads are combinational.
//
// Ports:
//   clk          in   1   rising-edge clock for all state
//   reset        in   1   synchronous active-high reset; rewrites the default image
//   PC_addr      in  32   byte fetch address
//   Instruction  out 32   fetched word, NOP_WORD when invalid or in reset
//   load_en      in   1   load-port write strobe
//   load_addr    in  32   byte address to write, same mapping as PC_addr
//   load_data    in  32   word to write
//   addr_fault   out  1   PC_addr misaligned or out of range (0 during reset)
//   fault_sticky out  1   set once any addr_fault is seen since reset
module instruction_memory #(
    parameter logic [31:0] BASE_ADDR = 32'd1000,
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_addr,
    output logic [31:0] Instruction,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        addr_fault,
    output logic        fault_sticky
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One bit wider than an address so the upper bound never wraps.
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * DEPTH);

    typedef logic [31:0] mem_t [DEPTH];

    function automatic logic [31:0] default_word(input int unsigned i);
        logic [31:0] w;
        w = NOP_WORD;
        unique case (i)
            0: w = 32'h0050_0093;
            1: w = 32'h0030_0113;
            2: w = 32'h0020_81B3;
            3: w = 32'h0030_2023;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    function automatic mem_t default_image();
        mem_t img;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            img[i] = default_word(i);
        end
        return img;
    endfunction

    function automatic logic addr_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) &&
               (a >= BASE_ADDR) &&
               ({1'b0, a} < END_ADDR);
    endfunction

    // Power-up contents equal the default image, so fetches before the
    // first reset already see the built-in program.
    mem_t mem_q = default_image();

    logic             fault_sticky_q;
    logic             fault_sticky_d;
    logic             pc_valid;
    logic             ld_valid;
    logic [31:0]      pc_off;
    logic [31:0]      ld_off;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] ld_idx;

    assign pc_valid = addr_valid(PC_addr);
    assign ld_valid = addr_valid(load_addr);

    assign pc_off = PC_addr - BASE_ADDR;
    assign ld_off = load_addr - BASE_ADDR;

    // Indices are only meaningful when the matching valid flag is set.
    assign pc_idx = IDX_W'(pc_off >> 2);
    assign ld_idx = IDX_W'(ld_off >> 2);

    assign Instruction = (!reset && pc_valid) ? mem_q[pc_idx] : NOP_WORD;
    assign addr_fault  = !reset && !pc_valid;

    assign fault_sticky_d = fault_sticky_q | addr_fault;
    assign fault_sticky   = fault_sticky_q;

    // Reset rewrites the whole image and takes priority over a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_word(i);
            end
        end else if (load_en && ld_valid) begin
            mem_q[ld_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_sticky_q <= 1'b0;
        end else begin
            fault_sticky_q <= fault_sticky_d;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed vectors for instruction_memory.
// Expected values are hand-computed constants.
module tb_instruction_memory;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] PC_addr;
    logic [31:0] Instruction;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        addr_fault;
    logic        fault_sticky;

    int n_vec;
    int n_err;

    instruction_memory dut (
        .clk         (clk),
        .reset       (reset),
        .PC_addr     (PC_addr),
        .Instruction (Instruction),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .addr_fault  (addr_fault),
        .fault_sticky(fault_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] exp_i,
                         input logic exp_f);
        PC_addr = a;
        #1;
        chk({tag, "_inst"}, Instruction, exp_i);
        chk({tag, "_fault"}, 32'(addr_fault), 32'(exp_f));
    endtask

    logic [31:0] img [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        img[0] = 32'h0050_0093;
        img[1] = 32'h0030_0113;
        img[2] = 32'h0020_81B3;
        img[3] = 32'h0030_2023;

        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = 32'd0;
        load_data = 32'd0;
        PC_addr   = 32'd1000;

        // Reset for two edges; outputs forced during reset.
        cyc();
        cyc();
        chk("rst_inst", Instruction, NOP);
        chk("rst_fault", 32'(addr_fault), 32'd0);
        chk("rst_sticky", 32'(fault_sticky), 32'd0);
        reset = 1'b0;

        // Default image.
        fetch("w0", 32'd1000, 32'h0050_0093, 1'b0);
        fetch("w1", 32'd1004, 32'h0030_0113, 1'b0);
        fetch("w2", 32'd1008, 32'h0020_81B3, 1'b0);
        fetch("w3", 32'd1012, 32'h0030_2023, 1'b0);
        cyc();
        chk("sticky_clean", 32'(fault_sticky), 32'd0);

        // Range boundaries.
        fetch("w4", 32'd1016, NOP, 1'b0);
        fetch("last", 32'd1252, NOP, 1'b0);
        cyc();
        chk("sticky_still0", 32'(fault_sticky), 32'd0);
        fetch("end", 32'd1256, NOP, 1'b1);
        fetch("below", 32'd996, NOP, 1'b1);
        cyc();
        chk("sticky_set", 32'(fault_sticky), 32'd1);
        fetch("misalign", 32'd1002, NOP, 1'b1);
        fetch("far", 32'hFFFF_FFFC, NOP, 1'b1);

        // Collision: old word before the edge, new word after.
        PC_addr   = 32'd1004;
        load_en   = 1'b1;
        load_addr = 32'd1004;
        load_data = 32'hDEAD_BEEF;
        #1;
        chk("coll_before", Instruction, 32'h0030_0113);
        cyc();
        chk("coll_after", Instruction, 32'hDEAD_BEEF);

        // Invalid loads are dropped.
        load_addr = 32'd1006;
        load_data = 32'h1111_1111;
        cyc();
        load_addr = 32'd2000;
        load_data = 32'h2222_2222;
        cyc();
        load_addr = 32'd996;
        load_data = 32'h3333_3333;
        cyc();
        // Last valid word accepts a load.
        load_addr = 32'd1252;
        load_data = 32'hCAFE_F00D;
        cyc();
        load_en = 1'b0;
        fetch("rb0", 32'd1000, 32'h0050_0093, 1'b0);
        fetch("rb1", 32'd1004, 32'hDEAD_BEEF, 1'b0);
        fetch("rb2", 32'd1008, 32'h0020_81B3, 1'b0);
        fetch("rb3", 32'd1012, 32'h0030_2023, 1'b0);
        fetch("rb_last", 32'd1252, 32'hCAFE_F00D, 1'b0);

        // Reset wins over a simultaneous load.
        reset     = 1'b1;
        load_en   = 1'b1;
        load_addr = 32'd1000;
        load_data = 32'h1234_5678;
        PC_addr   = 32'd1000;
        #1;
        chk("rst2_inst", Instruction, NOP);
        chk("rst2_fault", 32'(addr_fault), 32'd0);
        cyc();
        reset   = 1'b0;
        load_en = 1'b0;
        chk("rst2_sticky", 32'(fault_sticky), 32'd0);
        fetch("post0", 32'd1000, 32'h0050_0093, 1'b0);
        fetch("post1", 32'd1004, 32'h0030_0113, 1'b0);

        // Full sweep of the restored image.
        for (int i = 0; i < 64; i++) begin
            fetch($sformatf("sw%0d", i),
                  32'd1000 + 32'(4 * i),
                  (i < 4) ? img[i] : NOP,
                  1'b0);
        end
        cyc();
        chk("sweep_sticky", 32'(fault_sticky), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
Word-organised instruction store for the single-cycle RISC-V core. It maps byte program-counter addresses, starting at a base address, to 32-bit instruction words. Reads are combinational so the core can fetch and execute in the same cycle. A clocked load port allows the program to be replaced, and synchronous reset restores the built-in default program.

Parameters:
BASE_ADDR, 1000, byte address of word 0.
DEPTH, 64, number of 32-bit words stored.
NOP_WORD, 32'h00000013, word returned for invalid or unmapped fetches (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates happen on its rising edge.
reset  in  1  synchronous, active-high reset.
PC_addr  in  32  byte fetch address.
Instruction  out  32  fetched instruction word (combinational).
load_en  in  1  write strobe for the load port.
load_addr  in  32  byte address to write; uses the same mapping as PC_addr.
load_data  in  32  word to write.
addr_fault  out  1  combinational flag: current PC_addr is misaligned or out of range.
fault_sticky  out  1  registered flag: set once any addr_fault has been seen since reset.

Behaviour:
- Address mapping:
  - valid(a) = (a[1:0]==0) && (a >= BASE_ADDR) && (a < BASE_ADDR + 4*DEPTH).
  - index = (a - BASE_ADDR) >> 2.
  - Comparisons are unsigned, 32-bit, with no wrap-around.
- Read path is purely combinational, with no latency:
  - Instruction = mem[index(PC_addr)] when valid(PC_addr) and reset is low.
  - Otherwise Instruction = NOP_WORD.
- addr_fault = !valid(PC_addr), combinational. It is forced to 0 while reset is high.
- Default image, written into the array on every clock edge where reset is high:
  - word0 (addr 1000) = 32'h00500093 (addi x1,x0,5)
  - word1 (addr 1004) = 32'h00300113 (addi x2,x0,3)
  - word2 (addr 1008) = 32'h002081B3 (add x3,x1,x2)
  - word3 (addr 1012) = 32'h00302023 (sw x3,0(x0))
  - words 4..DEPTH-1 = NOP_WORD
- The array also holds the default image at simulation start, before the first reset.
- Reset effects:
  - fault_sticky clears to 0 on the reset edge.
  - Instruction reads NOP_WORD while reset is high.
  - Loads are ignored while reset is high; reset wins over a simultaneous load.
- Load port: on a rising clk with load_en=1, reset=0 and valid(load_addr), mem[index(load_addr)] <= load_data.
  - A load with an invalid load_addr is silently dropped, with no fault indication.
- Read/write collision: when a load targets the word currently addressed by PC_addr, Instruction shows the old word until the edge and the new word immediately after it. There is no write-through bypass.
- fault_sticky <= fault_sticky | addr_fault on each non-reset edge. It stays set until the next reset.
- Synthesis: the array is a DEPTH x 32 register array with combinational read, implemented as LUT/distributed memory. A block-RAM mapping is not required.

Test Plan:
1. Reset 2 cycles, release; PC_addr = 1000, 1004, 1008, 1012 at 10 ns each -> Instruction = 00500093, 00300113, 002081B3, 00302023; addr_fault = 0; fault_sticky = 0.
2. PC_addr = 1016 -> 00000013. PC_addr = 1000+4*64 = 1256 -> 00000013 with addr_fault = 1. PC_addr = 996 -> 00000013 with addr_fault = 1, and fault_sticky = 1 after the next edge.
3. PC_addr = 1002 (misaligned) -> Instruction = 00000013, addr_fault = 1.
4. load_en = 1, load_addr = 1004, load_data = DEADBEEF with PC_addr = 1004:
   - before the edge -> 00300113; after the edge -> DEADBEEF.
   - load_addr = 1006 or 2000 -> array unchanged (read back all 4 words).
5. After the test-4 load, assert reset for 1 cycle together with load_en = 1, load_addr = 1000, load_data = 12345678:
   - Instruction = 00000013 during reset.
   - After release: 1000 -> 00500093, 1004 -> 00300113; fault_sticky = 0.
6. Sweep PC_addr over all DEPTH words after reset -> words 0-3 match the default image, words 4-63 = 00000013, addr_fault stays 0 throughout.
